// File: rtl/serial_tx_shifter.sv
// Parallel-to-serial transmitter: a 1-entry holding buffer feeding a shift stage,
// so a new word can be queued while the current one is still being sent.
module serial_tx_shifter #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             data_valid,
    output logic             data_ready,
    output logic             din_out,
    output logic             bit_valid,
    output logic             word_last,
    output logic             busy
);

    localparam int unsigned       CNT_W    = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] shift_reg_q, shift_reg_d;
    logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
    logic [WIDTH-1:0] buf_data_q, buf_data_d;
    logic             buf_full_q, buf_full_d;

    logic             accept;
    logic             transfer;
    logic             last_bit;

    assign data_ready = !buf_full_q;
    assign accept     = data_valid && !buf_full_q;
    assign last_bit   = (state_q == SHIFT) && (bit_cnt_q == LAST_CNT);
    // A buffered word moves into the shifter either from idle or on the last-bit edge,
    // which is what lets back-to-back words go out with no gap.
    assign transfer   = buf_full_q && ((state_q == IDLE) || last_bit);

    assign bit_valid  = (state_q == SHIFT);
    assign word_last  = last_bit;
    assign busy       = (state_q == SHIFT) || buf_full_q;
    assign din_out    = (state_q == SHIFT) ? (MSB_FIRST ? shift_reg_q[WIDTH-1] : shift_reg_q[0])
                                           : 1'b0;

    // Holding buffer: accept and transfer never coincide, since accept needs it empty.
    always_comb begin
        // NOTE: every signal assigned here gets a default first, so no path infers a latch.
        buf_full_d = buf_full_q;
        buf_data_d = buf_data_q;
        if (transfer) begin
            buf_full_d = 1'b0;
        end else if (accept) begin
            buf_full_d = 1'b1;
            buf_data_d = data_in;
        end
    end

    always_comb begin
        state_d     = state_q;
        shift_reg_d = shift_reg_q;
        bit_cnt_d   = bit_cnt_q;
        if (transfer) begin
            state_d     = SHIFT;
            shift_reg_d = buf_data_q;
            bit_cnt_d   = '0;
        end else if (state_q == SHIFT) begin
            if (last_bit) begin
                state_d     = IDLE;
                shift_reg_d = '0;
                bit_cnt_d   = '0;
            end else begin
                if (MSB_FIRST) begin
                    shift_reg_d = {shift_reg_q[WIDTH-2:0], 1'b0};
                end else begin
                    shift_reg_d = {1'b0, shift_reg_q[WIDTH-1:1]};
                end
                bit_cnt_d = bit_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            shift_reg_q <= '0;
            bit_cnt_q   <= '0;
            buf_data_q  <= '0;
            buf_full_q  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q     <= state_d;
            shift_reg_q <= shift_reg_d;
            bit_cnt_q   <= bit_cnt_d;
            buf_data_q  <= buf_data_d;
            buf_full_q  <= buf_full_d;
        end
    end

endmodule

// File: tb/tb_serial_tx_shifter.sv
// Randomized bench for serial_tx_shifter: a timeline model of accepted words predicts
// every output cycle by cycle for an MSB-first and an LSB-first instance.
module tb_serial_tx_shifter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] data_in = '0;
    logic         data_valid = 1'b0;

    logic ready_m, dout_m, bv_m, wl_m, busy_m;
    logic ready_l, dout_l, bv_l, wl_l, busy_l;

    always #5 clk = ~clk;

    serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b1)) dut_msb (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_m), .din_out(dout_m), .bit_valid(bv_m),
        .word_last(wl_m), .busy(busy_m)
    );

    serial_tx_shifter #(.WIDTH(W), .MSB_FIRST(1'b0)) dut_lsb (
        .clk(clk), .rst(rst), .data_in(data_in), .data_valid(data_valid),
        .data_ready(ready_l), .din_out(dout_l), .bit_valid(bv_l),
        .word_last(wl_l), .busy(busy_l)
    );

    // Each accepted word: its data, the edge that accepted it, and the cycle its first bit appears.
    typedef struct {
        logic [W-1:0] data;
        int           acc;
        int           start;
    } word_t;

    word_t words[$];
    int    cyc   = 0;
    int    total = 0;
    int    bad   = 0;
    int    det_pulses = 0;
    logic [1:0] det_hist = 2'b00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h expected=%0h", tag, cyc, got, exp);
        end
    endtask

    // Buffer is occupied from the accepting edge until the word starts shifting.
    function automatic logic exp_ready(input int c);
        for (int i = 0; i < words.size(); i++)
            if (words[i].acc <= c && c < words[i].start) return 1'b0;
        return 1'b1;
    endfunction

    function automatic int active_word(input int c);
        for (int i = 0; i < words.size(); i++)
            if (words[i].start <= c && c < words[i].start + W) return i;
        return -1;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_dout_m"}, dout_m, 0);  check({tag, "_dout_l"}, dout_l, 0);
        check({tag, "_bv_m"},   bv_m,   0);  check({tag, "_bv_l"},   bv_l,   0);
        check({tag, "_wl_m"},   wl_m,   0);  check({tag, "_wl_l"},   wl_l,   0);
        check({tag, "_busy_m"}, busy_m, 0);  check({tag, "_busy_l"}, busy_l, 0);
        check({tag, "_rdy_m"},  ready_m, 1); check({tag, "_rdy_l"},  ready_l, 1);
    endtask

    task automatic check_cycle();
        int   k;
        int   pos;
        logic e_bv, e_bm, e_bl, e_wl, e_rdy, y;
        k     = active_word(cyc);
        e_bv  = (k >= 0);
        e_bm  = 1'b0;
        e_bl  = 1'b0;
        e_wl  = 1'b0;
        if (e_bv) begin
            pos  = cyc - words[k].start;
            e_bm = words[k].data[W-1-pos];
            e_bl = words[k].data[pos];
            e_wl = (pos == W - 1);
        end
        e_rdy = exp_ready(cyc);
        check("din_msb",  dout_m,  e_bm);
        check("din_lsb",  dout_l,  e_bl);
        check("bv_msb",   bv_m,    e_bv);
        check("bv_lsb",   bv_l,    e_bv);
        check("last_msb", wl_m,    e_wl);
        check("last_lsb", wl_l,    e_wl);
        check("rdy_msb",  ready_m, e_rdy);
        check("rdy_lsb",  ready_l, e_rdy);
        check("busy_msb", busy_m,  e_bv || !e_rdy);
        check("busy_lsb", busy_l,  e_bv || !e_rdy);
        // Downstream "110" detector fed by the MSB-first line.
        y = (det_hist == 2'b11) && (dout_m == 1'b0);
        if (y) det_pulses++;
        det_hist = {det_hist[0], dout_m};
    endtask

    task automatic step(input logic v, input logic [W-1:0] d);
        logic  acc;
        int    prev_last;
        word_t w;
        data_valid = v;
        data_in    = d;
        acc        = v && exp_ready(cyc);
        @(posedge clk);
        cyc++;
        if (acc) begin
            prev_last = (words.size() > 0) ? words[words.size()-1].start + W - 1 : -1000;
            w.data    = d;
            w.acc     = cyc;
            w.start   = (cyc + 1 > prev_last + 1) ? cyc + 1 : prev_last + 1;
            words.push_back(w);
        end
        @(negedge clk);
        check_cycle();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, W'($urandom));
    endtask

    initial begin
        // Power-on reset with data_valid high across an edge: nothing may be captured.
        data_valid = 1'b1;
        data_in    = 8'h5A;
        #2;
        check_reset_outputs("por_async");
        @(negedge clk);
        check_reset_outputs("por_held");
        rst        = 1'b1;
        data_valid = 1'b0;
        cyc        = 0;

        // Single word right after release; first bit two edges later.
        step(1'b1, 8'hB2);
        idle(11);

        // Buffer refilled while shifting: zero-gap back-to-back.
        step(1'b1, 8'hA5);
        step(1'b1, 8'h3C);
        step(1'b1, 8'h3C);
        idle(20);

        // Second word offered only on the last-bit cycle: one idle cycle between words.
        step(1'b1, 8'hC3);
        idle(8);
        step(1'b1, 8'h81);
        idle(12);

        // 8'h6C through the detector: two pulses, none from the idle line.
        det_pulses = 0;
        det_hist   = 2'b00;
        step(1'b1, 8'h6C);
        idle(14);
        check("det_pulses", det_pulses, 2);

        // Reset in the middle of 8'hFF at bit 4.
        step(1'b1, 8'hFF);
        idle(5);
        #2 rst = 1'b0;
        #1;
        check_reset_outputs("mid_async");
        data_valid = 1'b1;
        data_in    = 8'hE7;
        repeat (2) @(posedge clk);
        cyc += 2;
        @(negedge clk);
        check_reset_outputs("mid_held");
        words.delete();
        rst        = 1'b1;
        data_valid = 1'b0;
        idle(12);

        // Random traffic.
        for (int i = 0; i < 500; i++) step($urandom_range(0, 99) < 45, W'($urandom));
        idle(20);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
